// File: rtl/sha3_result_collector_if.sv
// Bundle of all job, pipe and hit-stream signals around the SHA3 result collector.
// slave  : the collector (takes job/pipe inputs, drives want_more, hit stream and status)
// master : whoever drives jobs, models the pipe and consumes hits
interface sha3_result_collector_if;
    logic             start;
    logic [31:0]      base_nonce;
    logic [31:0]      job_count;
    logic [63:0]      target;
    logic             issued;
    logic             want_more;
    logic             ogood;
    logic [4:0][63:0] oa;
    logic             hit_valid;
    logic             hit_ready;
    logic [31:0]      hit_nonce;
    logic [63:0]      hit_hash;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [7:0]       dropped;

    modport slave (
        input  start, base_nonce, job_count, target, issued, ogood, oa, hit_ready,
        output want_more, hit_valid, hit_nonce, hit_hash, busy, done, overrun, dropped
    );
    modport master (
        output start, base_nonce, job_count, target, issued, ogood, oa, hit_ready,
        input  want_more, hit_valid, hit_nonce, hit_hash, busy, done, overrun, dropped
    );
endinterface

// File: rtl/sha3_result_collector.sv
// Collects results of the iterating SHA3 pipe. Counts matrices issued, pairs each
// ogood burst with its nonce in issue order, compares oa[RESULT_LANE] < target and
// queues hits {nonce, hash} in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n : clock (posedge), asynchronous active-low reset
//   bus        : job load (start/base_nonce/job_count/target), pipe side
//                (issued/want_more/ogood/oa), hit stream (hit_valid/hit_ready/
//                hit_nonce/hit_hash) and status (busy/done/overrun/dropped)
module sha3_result_collector #(
    parameter int FIFO_DEPTH  = 4,
    parameter int RESULT_LANE = 0
) (
    input  logic clk,
    input  logic rst_n,
    sha3_result_collector_if.slave bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]  LANE    = 3'(RESULT_LANE);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state;
    logic [31:0] base_q, cnt_q, n_iss, n_ret;
    logic [63:0] tgt_q;
    logic        done_q, ovr_q;
    logic [7:0]  drop_q;

    // compare stage (cycle 1)
    logic        c1_hit;
    logic [31:0] c1_nonce;
    logic [63:0] c1_hash;

    // hit FIFO
    logic [31:0] mem_nonce [FIFO_DEPTH];
    logic [63:0] mem_hash  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic want_more, iss_ok, ret_ok, hit_valid, full, pop, push, drop;

    assign want_more = (state == SCAN) && (n_iss < cnt_q);
    assign iss_ok    = bus.issued && want_more;
    // a result only counts when something is actually outstanding in the pipe
    assign ret_ok    = bus.ogood && (n_iss != n_ret);
    assign hit_valid = (count != '0);
    assign full      = (count == DEPTH_C);
    assign pop       = hit_valid && bus.hit_ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push      = c1_hit && (!full || pop);
    assign drop      = c1_hit && full && !pop;

    assign bus.want_more = want_more;
    assign bus.hit_valid = hit_valid;
    assign bus.hit_nonce = hit_valid ? mem_nonce[rd_ptr] : '0;
    assign bus.hit_hash  = hit_valid ? mem_hash[rd_ptr]  : '0;
    assign bus.busy      = (state == SCAN) || (state == DRAIN);
    assign bus.done      = done_q;
    assign bus.overrun   = ovr_q;
    assign bus.dropped   = drop_q;

    // job FSM and counters; a start accepted later in the block overrides the counter updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
            cnt_q  <= '0;
            tgt_q  <= '0;
            n_iss  <= '0;
            n_ret  <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.issued && !want_more)     ovr_q <= 1'b1;
            if (bus.ogood && (n_iss == n_ret)) ovr_q <= 1'b1;
            if (iss_ok) n_iss <= n_iss + 32'd1;
            if (ret_ok) n_ret <= n_ret + 32'd1;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        base_q <= bus.base_nonce;
                        cnt_q  <= bus.job_count;
                        tgt_q  <= bus.target;
                        n_iss  <= '0;
                        n_ret  <= '0;
                        if (bus.job_count == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= SCAN;
                        end
                    end
                end
                SCAN:  if (n_iss == cnt_q) state <= DRAIN;
                DRAIN: begin
                    if (n_ret == cnt_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cycle 1: pair result with its nonce (wraps mod 2^32) and compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_hit   <= 1'b0;
            c1_nonce <= '0;
            c1_hash  <= '0;
        end else begin
            c1_hit   <= ret_ok && (bus.oa[LANE] < tgt_q);
            c1_nonce <= base_q + n_ret;
            c1_hash  <= bus.oa[LANE];
        end
    end

    // cycle 2: push into FIFO; head visible the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_nonce[i] <= '0;
                mem_hash[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_nonce[wr_ptr] <= c1_nonce;
                mem_hash[wr_ptr]  <= c1_hash;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end
endmodule
